tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- Backend sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB, issued from the execute stage.
- Drives the write, invalidate, read-index and search-request side of the address-translation unit, and captures its read/search results into CSR write-back strobes.
- Generates the random TLBFILL index and a refetch request after any TLB-modifying operation.
- Sits between the execute stage, the CSR file and addr_trans.

Parameters:
- TLBNUM, 32, number of TLB entries (power of two).
- IDX_W, 5, index width = log2(TLBNUM).
- LFSR_SEED, 5'b00001, reset value of the random-index LFSR (must be nonzero).

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- op_valid in 1: operation request.
- op_ready out 1: high only in IDLE.
- op_type in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; others reserved.
- inv_op in 5: INVTLB op field.
- inv_asid in 10: INVTLB rj[9:0].
- inv_vpn in 19: INVTLB rk[31:13].
- flush in 1: pipeline flush/exception.
- csr_tlbehi in 32, csr_tlbidx in 32: current CSR values.
- tlbfill_en out 1, tlbwr_en out 1, rand_index out IDX_W: write port to addr_trans.
- invtlb_en out 1, invtlb_op out 5, invtlb_asid out 10, invtlb_vpn out 19: invalidate port.
- srch_req out 1: request for the data-side translation port.
- srch_gnt in 1: LSU arbiter grant; pulses data_fetch.
- srch_vaddr out 32: {csr_tlbehi[31:13],13'b0}.
- srch_found in 1, srch_index in IDX_W: registered search results.
- tlbehi_rd in 32, tlbelo0_rd in 32, tlbelo1_rd in 32, tlbidx_rd in 32, asid_rd in 10: combinational read data for entry csr_tlbidx[IDX_W-1:0].
- csr_we_tlbehi, csr_we_tlbelo0, csr_we_tlbelo1, csr_we_tlbidx, csr_we_asid out 1 each.
- csr_wdata_tlbehi, csr_wdata_tlbelo0, csr_wdata_tlbelo1, csr_wdata_tlbidx out 32 each.
- csr_wdata_asid out 10.
- refetch out 1, op_done out 1, ine_excp out 1: single-cycle pulses.

Behaviour:
- Reset:
  - FSM returns to IDLE from any state.
  - All enables, strobes and pulses are 0; all data outputs are 0.
  - LFSR is loaded with LFSR_SEED.
  - Reset mid-operation discards the operation silently.
- FSM states: IDLE, SRCH_REQ, SRCH_WAIT, RD_CAP, WR, INV, DONE.
- Accept: op_valid & op_ready. The op fields are latched at acceptance.
- SRCH:
  - IDLE->SRCH_REQ. Hold srch_req=1 until srch_gnt; then SRCH_WAIT.
  - SRCH_WAIT (1 cycle) samples srch_found/srch_index, then goes to DONE.
  - Found: csr_we_tlbidx=1 with wdata = csr_tlbidx, index field := srch_index, bit31 (NE) := 0.
  - Not found: csr_we_tlbidx=1 with wdata = csr_tlbidx, NE := 1, index and PS unchanged.
- RD:
  - IDLE->RD_CAP (1 cycle), then DONE.
  - In RD_CAP, if tlbidx_rd[31]==0 (entry valid):
    - write tlbehi, tlbelo0, tlbelo1 and asid from the *_rd inputs;
    - write tlbidx = {0, csr_tlbidx[30], tlbidx_rd[29:24], csr_tlbidx[23:0]}.
  - If tlbidx_rd[31]==1 (entry invalid):
    - write 0 to tlbehi, tlbelo0, tlbelo1 and asid;
    - write tlbidx with NE=1, PS=0, index kept.
- WR/FILL:
  - IDLE->WR. In WR, assert tlbwr_en or tlbfill_en for exactly one cycle.
  - rand_index = current LFSR value, masked to IDX_W bits.
  - Next state DONE, with refetch=1 in DONE.
- INV:
  - inv_op <= 6: IDLE->INV. In INV, one-cycle invtlb_en with latched fields; then DONE with refetch=1.
  - inv_op > 6: no invtlb_en; ine_excp=1 in DONE; no refetch.
- Reserved op_type: ine_excp=1, otherwise identical to an invalid INV.
- DONE: op_done=1 for one cycle, then IDLE.
- CSR strobes are asserted for exactly one cycle: in SRCH_WAIT for SRCH, in RD_CAP for RD.
- Flush:
  - In SRCH_REQ, SRCH_WAIT or RD_CAP: abort to IDLE with no CSR strobes and no op_done.
  - In WR, INV or DONE: ignored. The pulse/commit already issued completes.
  - In IDLE: ignored. flush and op_valid in the same IDLE cycle: the op is not accepted.
- LFSR:
  - 5-bit maximal-length, taps x^5+x^3+1; steps every cycle; never 0.
  - Value used by FILL is the one present in the WR cycle.
- Simultaneous srch_gnt and flush in SRCH_REQ: flush wins; the result is discarded.

Decomposition:
- Shared package/define header holds:
  - op_type encodings (TLBOP_SRCH..TLBOP_INV);
  - FSM state encodings;
  - CSR field ranges INDEX, PS, NE, VPPN (reuse existing csr defines);
  - INVTLB_MAX_OP = 6.
- One natural sub-module: lfsr5_rand (enable-free free-running LFSR with seed parameter).

Test Plan:
- SRCH hit: csr_tlbehi=0x1234_6000, grant after 2 cycles, srch_found=1, srch_index=7 -> csr_we_tlbidx pulse, wdata[31]=0, [4:0]=7, op_done 1 cycle later.
- SRCH miss: csr_tlbidx=0x0C00_0003, srch_found=0 -> wdata=0x8C00_0003.
- RD invalid entry: tlbidx_rd[31]=1 -> tlbehi, elo0, elo1 and asid written 0; tlbidx NE=1, PS=0, index 3 preserved.
- FILL twice after reset: rand_index = successive LFSR values, both nonzero and distinct; tlbfill_en high exactly 1 cycle each; refetch pulses.
- INV op=7 -> no invtlb_en, ine_excp pulse, op_done. INV op=5, asid=0x2A, vpn=0x1_2345 -> invtlb_en 1 cycle with those values.
- Flush in SRCH_WAIT -> no csr_we_tlbidx, no op_done, op_ready next cycle. rst asserted during RD_CAP -> all outputs 0, op_ready=1 after reset.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB maintenance sequencer: op codes, FSM states,
// CSR field positions and the per-operation completion flags.
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SRCH_REQ  = 3'd1,
        ST_SRCH_WAIT = 3'd2,
        ST_RD_CAP    = 3'd3,
        ST_WR        = 3'd4,
        ST_INV       = 3'd5,
        ST_DONE      = 3'd6
    } tlb_state_e;

    // TLBIDX: NE bit, PS field; TLBEHI: VPPN field
    localparam int unsigned TLBIDX_NE       = 31;
    localparam int unsigned TLBIDX_PS_MSB   = 29;
    localparam int unsigned TLBIDX_PS_LSB   = 24;
    localparam int unsigned TLBEHI_VPPN_MSB = 31;
    localparam int unsigned TLBEHI_VPPN_LSB = 13;

    localparam logic [4:0] INVTLB_MAX_OP = 5'd6;

    // What the DONE cycle must report for the accepted operation
    typedef struct packed {
        logic fill;
        logic refetch;
        logic ine;
    } op_kind_t;

endpackage

// File: rtl/tlb_op_ctrl_lfsr5_rand.sv
// Free-running 5-bit maximal-length LFSR (x^5 + x^3 + 1) for the TLBFILL index.
// rand_nxt_o is the value the register takes at the next clock edge.
module lfsr5_rand #(
    parameter logic [4:0] SEED = 5'b00001
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] rand_nxt_o
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    assign lfsr_d     = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    assign rand_nxt_o = lfsr_d;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between execute, the CSR
// file and addr_trans. Port-side pulses are registered; CSR write-back is a
// same-cycle capture of the addr_trans read/search results.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM    = 32,
    parameter int unsigned IDX_W     = 5,
    parameter logic [4:0]  LFSR_SEED = 5'b00001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_type,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vpn,
    input  logic             flush,
    input  logic [31:0]      csr_tlbehi,
    input  logic [31:0]      csr_tlbidx,
    output logic             tlbfill_en,
    output logic             tlbwr_en,
    output logic [IDX_W-1:0] rand_index,
    output logic             invtlb_en,
    output logic [4:0]       invtlb_op,
    output logic [9:0]       invtlb_asid,
    output logic [18:0]      invtlb_vpn,
    output logic             srch_req,
    input  logic             srch_gnt,
    output logic [31:0]      srch_vaddr,
    input  logic             srch_found,
    input  logic [IDX_W-1:0] srch_index,
    input  logic [31:0]      tlbehi_rd,
    input  logic [31:0]      tlbelo0_rd,
    input  logic [31:0]      tlbelo1_rd,
    input  logic [31:0]      tlbidx_rd,
    input  logic [9:0]       asid_rd,
    output logic             csr_we_tlbehi,
    output logic             csr_we_tlbelo0,
    output logic             csr_we_tlbelo1,
    output logic             csr_we_tlbidx,
    output logic             csr_we_asid,
    output logic [31:0]      csr_wdata_tlbehi,
    output logic [31:0]      csr_wdata_tlbelo0,
    output logic [31:0]      csr_wdata_tlbelo1,
    output logic [31:0]      csr_wdata_tlbidx,
    output logic [9:0]       csr_wdata_asid,
    output logic             refetch,
    output logic             op_done,
    output logic             ine_excp
);

    localparam logic [4:0] RAND_MASK = 5'(TLBNUM - 1);

    tlb_state_e state_q, state_d;
    op_kind_t   kind_q, kind_d;
    logic       accept;
    logic [4:0] rand_nxt;

    logic             op_ready_q, tlbfill_en_q, tlbwr_en_q, invtlb_en_q, srch_req_q;
    logic             refetch_q, op_done_q, ine_excp_q;
    logic [IDX_W-1:0] rand_index_q;
    logic [4:0]       invtlb_op_q;
    logic [9:0]       invtlb_asid_q;
    logic [18:0]      invtlb_vpn_q;
    logic [31:0]      srch_vaddr_q;

    logic unused_bits;
    assign unused_bits = ^{csr_tlbehi[TLBEHI_VPPN_LSB-1:0], csr_tlbidx[TLBIDX_NE],
                           tlbidx_rd[30], tlbidx_rd[23:0]};

    lfsr5_rand #(.SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .rand_nxt_o (rand_nxt)
    );

    // flush in IDLE blocks acceptance of a same-cycle request
    assign accept = op_valid & (state_q == ST_IDLE) & ~flush;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d = '0;
                    case (op_type)
                        TLBOP_SRCH: state_d = ST_SRCH_REQ;
                        TLBOP_RD:   state_d = ST_RD_CAP;
                        TLBOP_WR: begin
                            state_d        = ST_WR;
                            kind_d.refetch = 1'b1;
                        end
                        TLBOP_FILL: begin
                            state_d        = ST_WR;
                            kind_d.fill    = 1'b1;
                            kind_d.refetch = 1'b1;
                        end
                        TLBOP_INV: begin
                            if (inv_op <= INVTLB_MAX_OP) begin
                                state_d        = ST_INV;
                                kind_d.refetch = 1'b1;
                            end else begin
                                state_d    = ST_DONE;
                                kind_d.ine = 1'b1;
                            end
                        end
                        default: begin
                            state_d    = ST_DONE;
                            kind_d.ine = 1'b1;
                        end
                    endcase
                end
            end
            ST_SRCH_REQ: begin
                if (flush)         state_d = ST_IDLE;
                else if (srch_gnt) state_d = ST_SRCH_WAIT;
            end
            ST_SRCH_WAIT,
            ST_RD_CAP: state_d = flush ? ST_IDLE : ST_DONE;
            ST_WR,
            ST_INV:    state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pulses are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= '0;
            op_ready_q    <= 1'b1;
            tlbfill_en_q  <= 1'b0;
            tlbwr_en_q    <= 1'b0;
            rand_index_q  <= '0;
            invtlb_en_q   <= 1'b0;
            invtlb_op_q   <= '0;
            invtlb_asid_q <= '0;
            invtlb_vpn_q  <= '0;
            srch_req_q    <= 1'b0;
            srch_vaddr_q  <= '0;
            refetch_q     <= 1'b0;
            op_done_q     <= 1'b0;
            ine_excp_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            op_ready_q    <= (state_d == ST_IDLE);
            tlbfill_en_q  <= (state_d == ST_WR) &  kind_d.fill;
            tlbwr_en_q    <= (state_d == ST_WR) & ~kind_d.fill;
            rand_index_q  <= (state_d == ST_WR) ? IDX_W'(rand_nxt & RAND_MASK) : '0;
            invtlb_en_q   <= (state_d == ST_INV);
            invtlb_op_q   <= (state_d == ST_INV) ? inv_op   : '0;
            invtlb_asid_q <= (state_d == ST_INV) ? inv_asid : '0;
            invtlb_vpn_q  <= (state_d == ST_INV) ? inv_vpn  : '0;
            srch_req_q    <= (state_d == ST_SRCH_REQ);
            srch_vaddr_q  <= (state_d == ST_SRCH_REQ) ?
                             {csr_tlbehi[TLBEHI_VPPN_MSB:TLBEHI_VPPN_LSB], 13'b0} : '0;
            refetch_q     <= (state_d == ST_DONE) & kind_d.refetch;
            op_done_q     <= (state_d == ST_DONE);
            ine_excp_q    <= (state_d == ST_DONE) & kind_d.ine;
        end
    end

    // CSR write-back captures addr_trans results in the cycle they are valid
    always_comb begin
        csr_we_tlbehi     = 1'b0;
        csr_we_tlbelo0    = 1'b0;
        csr_we_tlbelo1    = 1'b0;
        csr_we_tlbidx     = 1'b0;
        csr_we_asid       = 1'b0;
        csr_wdata_tlbehi  = '0;
        csr_wdata_tlbelo0 = '0;
        csr_wdata_tlbelo1 = '0;
        csr_wdata_tlbidx  = '0;
        csr_wdata_asid    = '0;
        if (!rst && !flush) begin
            if (state_q == ST_SRCH_WAIT) begin
                csr_we_tlbidx    = 1'b1;
                csr_wdata_tlbidx = csr_tlbidx;
                if (srch_found) begin
                    csr_wdata_tlbidx[TLBIDX_NE]   = 1'b0;
                    csr_wdata_tlbidx[IDX_W-1:0]   = srch_index;
                end else begin
                    csr_wdata_tlbidx[TLBIDX_NE]   = 1'b1;
                end
            end else if (state_q == ST_RD_CAP) begin
                csr_we_tlbehi  = 1'b1;
                csr_we_tlbelo0 = 1'b1;
                csr_we_tlbelo1 = 1'b1;
                csr_we_tlbidx  = 1'b1;
                csr_we_asid    = 1'b1;
                if (!tlbidx_rd[TLBIDX_NE]) begin
                    csr_wdata_tlbehi  = tlbehi_rd;
                    csr_wdata_tlbelo0 = tlbelo0_rd;
                    csr_wdata_tlbelo1 = tlbelo1_rd;
                    csr_wdata_asid    = asid_rd;
                    csr_wdata_tlbidx  = {1'b0, csr_tlbidx[30],
                                         tlbidx_rd[TLBIDX_PS_MSB:TLBIDX_PS_LSB],
                                         csr_tlbidx[23:0]};
                end else begin
                    csr_wdata_tlbidx  = {1'b1, csr_tlbidx[30], 6'b0, csr_tlbidx[23:0]};
                end
            end
        end
    end

    assign op_ready    = op_ready_q;
    assign tlbfill_en  = tlbfill_en_q;
    assign tlbwr_en    = tlbwr_en_q;
    assign rand_index  = rand_index_q;
    assign invtlb_en   = invtlb_en_q;
    assign invtlb_op   = invtlb_op_q;
    assign invtlb_asid = invtlb_asid_q;
    assign invtlb_vpn  = invtlb_vpn_q;
    assign srch_req    = srch_req_q;
    assign srch_vaddr  = srch_vaddr_q;
    assign refetch     = refetch_q;
    assign op_done     = op_done_q;
    assign ine_excp    = ine_excp_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: operation tasks describe, cycle by cycle, what every
// output must show; one negedge process compares the DUT against that.
module tb_tlb_op_ctrl;

    localparam int unsigned IDX_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic op_valid, op_ready, flush, srch_gnt, srch_found;
    logic [2:0] op_type;
    logic [4:0] inv_op;
    logic [9:0] inv_asid, asid_rd;
    logic [18:0] inv_vpn;
    logic [31:0] csr_tlbehi, csr_tlbidx, tlbehi_rd, tlbelo0_rd, tlbelo1_rd, tlbidx_rd;
    logic [IDX_W-1:0] srch_index, rand_index;
    logic tlbfill_en, tlbwr_en, invtlb_en, srch_req, refetch, op_done, ine_excp;
    logic [4:0] invtlb_op;
    logic [9:0] invtlb_asid, csr_wdata_asid;
    logic [18:0] invtlb_vpn;
    logic [31:0] srch_vaddr, csr_wdata_tlbehi, csr_wdata_tlbelo0, csr_wdata_tlbelo1, csr_wdata_tlbidx;
    logic csr_we_tlbehi, csr_we_tlbelo0, csr_we_tlbelo1, csr_we_tlbidx, csr_we_asid;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(32), .IDX_W(IDX_W), .LFSR_SEED(5'b00001)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn), .flush(flush),
        .csr_tlbehi(csr_tlbehi), .csr_tlbidx(csr_tlbidx),
        .tlbfill_en(tlbfill_en), .tlbwr_en(tlbwr_en), .rand_index(rand_index),
        .invtlb_en(invtlb_en), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
        .invtlb_vpn(invtlb_vpn), .srch_req(srch_req), .srch_gnt(srch_gnt),
        .srch_vaddr(srch_vaddr), .srch_found(srch_found), .srch_index(srch_index),
        .tlbehi_rd(tlbehi_rd), .tlbelo0_rd(tlbelo0_rd), .tlbelo1_rd(tlbelo1_rd),
        .tlbidx_rd(tlbidx_rd), .asid_rd(asid_rd),
        .csr_we_tlbehi(csr_we_tlbehi), .csr_we_tlbelo0(csr_we_tlbelo0),
        .csr_we_tlbelo1(csr_we_tlbelo1), .csr_we_tlbidx(csr_we_tlbidx), .csr_we_asid(csr_we_asid),
        .csr_wdata_tlbehi(csr_wdata_tlbehi), .csr_wdata_tlbelo0(csr_wdata_tlbelo0),
        .csr_wdata_tlbelo1(csr_wdata_tlbelo1), .csr_wdata_tlbidx(csr_wdata_tlbidx),
        .csr_wdata_asid(csr_wdata_asid), .refetch(refetch), .op_done(op_done), .ine_excp(ine_excp)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Expected outputs for the current cycle
    logic e_op_ready, e_fill, e_wr, e_inv, e_req, e_refetch, e_done, e_ine;
    logic [4:0]  e_we;   // {tlbehi, elo0, elo1, tlbidx, asid}
    logic [IDX_W-1:0] e_rand;
    logic [4:0]  e_iop;
    logic [9:0]  e_iasid, e_wd_asid;
    logic [18:0] e_ivpn;
    logic [31:0] e_vaddr, e_wd_ehi, e_wd_elo0, e_wd_elo1, e_wd_idx;

    // Reference LFSR sequence: x^5 + x^3 + 1, seed 1, one step per clock
    logic [4:0] lfsr_m;
    always @(posedge clk) lfsr_m <= rst ? 5'd1 : {lfsr_m[3:0], lfsr_m[4] ^ lfsr_m[2]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ctrl", 32'({op_ready, tlbfill_en, tlbwr_en, invtlb_en, srch_req, refetch, op_done, ine_excp}),
                32'({e_op_ready, e_fill, e_wr, e_inv, e_req, e_refetch, e_done, e_ine}));
            chk("csr_we", 32'({csr_we_tlbehi, csr_we_tlbelo0, csr_we_tlbelo1, csr_we_tlbidx, csr_we_asid}),
                32'(e_we));
            chk("rand_index", 32'(rand_index), 32'(e_rand));
            chk("invtlb_fields", {invtlb_op[2:0], invtlb_asid, invtlb_vpn}, {e_iop[2:0], e_iasid, e_ivpn});
            chk("invtlb_op", 32'(invtlb_op), 32'(e_iop));
            chk("srch_vaddr", srch_vaddr, e_vaddr);
            chk("wdata_tlbehi", csr_wdata_tlbehi, e_wd_ehi);
            chk("wdata_tlbelo0", csr_wdata_tlbelo0, e_wd_elo0);
            chk("wdata_tlbelo1", csr_wdata_tlbelo1, e_wd_elo1);
            chk("wdata_tlbidx", csr_wdata_tlbidx, e_wd_idx);
            chk("wdata_asid", 32'(csr_wdata_asid), 32'(e_wd_asid));
        end
    end

    task automatic set_exp(input bit busy);
        e_op_ready = !busy;
        {e_fill, e_wr, e_inv, e_req, e_refetch, e_done, e_ine} = '0;
        e_we = '0; e_rand = '0; e_iop = '0; e_iasid = '0; e_ivpn = '0; e_vaddr = '0;
        e_wd_ehi = '0; e_wd_elo0 = '0; e_wd_elo1 = '0; e_wd_idx = '0; e_wd_asid = '0;
    endtask

    // Advance one clock; busy says the DUT is mid-operation in the new cycle,
    // where unrelated inputs are scrambled to show the op was latched.
    task automatic next_cycle(input bit busy);
        @(posedge clk); #1;
        set_exp(busy);
        op_valid = busy ? 1'($urandom) : 1'b0;
        flush = 1'b0; srch_gnt = 1'b0;
        op_type = 3'($urandom); inv_op = 5'($urandom);
        inv_asid = 10'($urandom); inv_vpn = 19'($urandom);
        srch_found = 1'($urandom); srch_index = IDX_W'($urandom);
        tlbehi_rd = $urandom; tlbelo0_rd = $urandom; tlbelo1_rd = $urandom;
        tlbidx_rd = $urandom; asid_rd = 10'($urandom);
    endtask

    task automatic pin(input string name, input bit en, input logic [31:0] act_sel, input logic [31:0] exp);
        logic [31:0] act;
        if (en) begin
            @(negedge clk);
            act = (act_sel == 0) ? csr_wdata_tlbidx : 32'(rand_index);
            chk(name, act, exp);
        end
    endtask

    task automatic do_srch(input bit found, input logic [IDX_W-1:0] idx, input int gdelay,
                           input bit flush_gnt, input bit flush_wait, input bit pin_en,
                           input logic [31:0] pin_v);
        op_valid = 1'b1; op_type = 3'd0;
        for (int k = 0; k <= gdelay; k++) begin
            next_cycle(1'b1);
            e_req = 1'b1;
            e_vaddr = {csr_tlbehi[31:13], 13'b0};
            if (k == gdelay) begin srch_gnt = 1'b1; flush = flush_gnt; end
        end
        if (flush_gnt) begin next_cycle(1'b0); return; end
        next_cycle(1'b1);
        srch_found = found; srch_index = idx; flush = flush_wait;
        if (!flush_wait) begin
            e_we = 5'b00010;
            e_wd_idx = found ? {1'b0, csr_tlbidx[30:IDX_W], idx} : {1'b1, csr_tlbidx[30:0]};
        end
        pin("srch_wdata_pin", pin_en, 0, pin_v);
        if (flush_wait) begin next_cycle(1'b0); return; end
        next_cycle(1'b1); e_done = 1'b1; flush = 1'($urandom);
        next_cycle(1'b0);
    endtask

    task automatic do_rd(input bit valid, input bit flush_cap, input bit rst_cap,
                         input bit pin_en, input logic [31:0] pin_v);
        op_valid = 1'b1; op_type = 3'd1;
        next_cycle(1'b1);
        tlbidx_rd[31] = !valid;
        if (rst_cap) begin
            rst = 1'b1;
            next_cycle(1'b0);
            rst = 1'b0;
            return;
        end
        flush = flush_cap;
        if (!flush_cap) begin
            e_we = 5'b11111;
            if (valid) begin
                e_wd_ehi = tlbehi_rd; e_wd_elo0 = tlbelo0_rd; e_wd_elo1 = tlbelo1_rd; e_wd_asid = asid_rd;
                e_wd_idx = {1'b0, csr_tlbidx[30], tlbidx_rd[29:24], csr_tlbidx[23:0]};
            end else begin
                e_wd_idx = {1'b1, csr_tlbidx[30], 6'b0, csr_tlbidx[23:0]};
            end
        end
        pin("rd_wdata_pin", pin_en, 0, pin_v);
        if (flush_cap) begin next_cycle(1'b0); return; end
        next_cycle(1'b1); e_done = 1'b1;
        next_cycle(1'b0);
    endtask

    task automatic do_wr(input bit fill, input bit pin_en, input logic [31:0] pin_v);
        op_valid = 1'b1; op_type = fill ? 3'd3 : 3'd2;
        next_cycle(1'b1);
        e_fill = fill; e_wr = !fill; e_rand = lfsr_m; flush = 1'($urandom);
        pin("fill_rand_pin", pin_en, 1, pin_v);
        next_cycle(1'b1);
        e_done = 1'b1; e_refetch = 1'b1; flush = 1'($urandom);
        next_cycle(1'b0);
    endtask

    task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vpn);
        op_valid = 1'b1; op_type = 3'd4; inv_op = op; inv_asid = asid; inv_vpn = vpn;
        if (op <= 5'd6) begin
            next_cycle(1'b1);
            e_inv = 1'b1; e_iop = op; e_iasid = asid; e_ivpn = vpn; flush = 1'($urandom);
        end
        next_cycle(1'b1);
        e_done = 1'b1; e_refetch = (op <= 5'd6); e_ine = (op > 5'd6);
        next_cycle(1'b0);
    endtask

    task automatic do_rsv(input logic [2:0] t);
        op_valid = 1'b1; op_type = t;
        next_cycle(1'b1); e_done = 1'b1; e_ine = 1'b1;
        next_cycle(1'b0);
    endtask

    task automatic idle_flush();
        op_valid = 1'b1; flush = 1'b1; op_type = 3'($urandom);
        next_cycle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; flush = 1'b0; srch_gnt = 1'b0; op_type = '0;
        inv_op = '0; inv_asid = '0; inv_vpn = '0; csr_tlbehi = '0; csr_tlbidx = '0;
        srch_found = 1'b0; srch_index = '0; tlbehi_rd = '0; tlbelo0_rd = '0;
        tlbelo1_rd = '0; tlbidx_rd = '0; asid_rd = '0;
        set_exp(1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // Two FILLs straight after reset: LFSR 1 -> 2 (first WR) ... -> 18 (second WR)
        do_wr(1'b1, 1'b1, 32'd2);
        do_wr(1'b1, 1'b1, 32'd18);
        do_wr(1'b0, 1'b0, 32'd0);

        csr_tlbehi = 32'h1234_6000; csr_tlbidx = 32'h0C00_0003;
        do_srch(1'b1, 5'd7, 2, 1'b0, 1'b0, 1'b1, 32'h0C00_0007);
        do_srch(1'b0, 5'd9, 0, 1'b0, 1'b0, 1'b1, 32'h8C00_0003);

        csr_tlbidx = 32'h4A00_0003;
        do_rd(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0003);
        do_rd(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        do_inv(5'd7, 10'h155, 19'h7_0000);
        do_inv(5'd5, 10'h02A, 19'h1_2345);
        do_rsv(3'd6);

        do_srch(1'b1, 5'd4, 1, 1'b0, 1'b1, 1'b0, 32'd0);   // flush in SRCH_WAIT
        do_srch(1'b1, 5'd4, 1, 1'b1, 1'b0, 1'b0, 32'd0);   // flush with grant
        do_rd(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);              // flush in RD_CAP
        idle_flush();
        do_rd(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);              // reset in RD_CAP
        do_wr(1'b1, 1'b1, 32'd2);                          // LFSR restarted from seed

        for (int i = 0; i < 300; i++) begin
            csr_tlbehi = $urandom; csr_tlbidx = $urandom;
            case ($urandom_range(0, 7))
                0: do_srch(1'($urandom), IDX_W'($urandom), int'($urandom_range(0, 3)),
                           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0, 32'd0);
                1: do_rd(1'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 32'd0);
                2: do_wr(1'b0, 1'b0, 32'd0);
                3: do_wr(1'b1, 1'b0, 32'd0);
                4: do_inv(5'($urandom_range(0, 9)), 10'($urandom), 19'($urandom));
                5: do_rsv(3'($urandom_range(5, 7)));
                6: idle_flush();
                default: next_cycle(1'b0);
            endcase
        end

        next_cycle(1'b0);
        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
